// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-queue FSM states, queue defaults and the
// baud-select codes understood by uart_transmitter / uart_receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } txq_state_t;

  localparam int DEFAULT_TXQ_DEPTH    = 4;
  localparam int DEFAULT_BUSY_TIMEOUT = 8;

  localparam logic [2:0] BAUD_SEL_300    = 3'b000;
  localparam logic [2:0] BAUD_SEL_1200   = 3'b001;
  localparam logic [2:0] BAUD_SEL_4800   = 3'b010;
  localparam logic [2:0] BAUD_SEL_9600   = 3'b011;
  localparam logic [2:0] BAUD_SEL_19200  = 3'b100;
  localparam logic [2:0] BAUD_SEL_38400  = 3'b101;
  localparam logic [2:0] BAUD_SEL_57600  = 3'b110;
  localparam logic [2:0] BAUD_SEL_115200 = 3'b111;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO for the UART transmit queue: storage, wrap-bit pointers,
// full/empty/level and a sticky overflow flag.
// Optional UART_TXQ_DROP_CNT_EN adds a saturating dropped-push counter.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_TXQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef UART_TXQ_DROP_CNT_EN
  , output logic [7:0]             drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0] mem [DEPTH];
  logic [PW:0] wptr;
  logic [PW:0] rptr;
  logic        accept;
  logic        advance;
  logic        drop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign level   = wptr - rptr;
  assign head    = mem[rptr[PW-1:0]];
  assign advance = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign accept  = push && (!full || advance);
  assign drop    = push && full && !advance;

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr[PW-1:0]] <= push_data;
  end

  // Pointer and sticky overflow maintenance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept)  wptr <= wptr + 1'b1;
      if (advance) rptr <= rptr + 1'b1;
      if (drop)    overflow <= 1'b1;
    end
  end

`ifdef UART_TXQ_DROP_CNT_EN
  // Saturating count of dropped pushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt <= '0;
    else if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: rtl/uart_tx_scheduler.sv
// Transmit-side byte queue feeding uart_transmitter: buffers host bytes and
// issues them one at a time with a Tx_WR pulse, following Tx_BUSY.
// Optional UART_TXQ_DROP_CNT_EN exposes drop_cnt (saturating dropped pushes).
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_TXQ_DEPTH,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [7:0]             wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   stall,
  output logic [7:0]             Tx_DATA,
  output logic                   Tx_WR,
  input  logic                   Tx_BUSY
`ifdef UART_TXQ_DROP_CNT_EN
  , output logic [7:0]           drop_cnt
`endif
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  txq_state_t    state;
  logic [CW-1:0] cnt;
  logic [7:0]    head;
  logic          pop;

  // Head leaves the queue only once the transmitter has accepted it.
  assign pop = (state == WAIT_BUSY) && Tx_BUSY;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow)
`ifdef UART_TXQ_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // Issue/handshake FSM with registered Tx_WR, Tx_DATA and stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      Tx_WR   <= 1'b0;
      Tx_DATA <= '0;
      stall   <= 1'b0;
      cnt     <= '0;
    end else begin
      Tx_WR <= 1'b0;
      case (state)
        IDLE: begin
          if (en && !empty && !Tx_BUSY) begin
            Tx_DATA <= head;
            Tx_WR   <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (Tx_BUSY) begin
            stall <= 1'b0;
            state <= WAIT_DONE;
          end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
            stall <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!Tx_BUSY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
